// File: rtl/tnn_feature_loader.sv
// Front-end for the 5-input 3-bit TNN neuron: quantises raw samples into a 5-feature frame,
// registers the neuron decision and returns it on a valid/ready stream. Optional stats: TNN_LOADER_STATS_EN.
module tnn_feature_loader #(
   parameter int unsigned RAW_W  = 8,
   parameter int unsigned QSHIFT = 5,
   parameter int unsigned STAT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RAW_W-1:0] in_data,
   input  logic             in_last,
   output logic [2:0]       feat_a,
   output logic [2:0]       feat_b,
   output logic [2:0]       feat_c,
   output logic [2:0]       feat_d,
   output logic [2:0]       feat_e,
   input  logic             nrn_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_class,
   output logic             frame_err,
   input  logic             clr_err
`ifdef TNN_LOADER_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_total,
   output logic [STAT_W-1:0] stat_pos
`endif
);

   typedef enum logic [1:0] {COLLECT, EVAL, HOLD} state_t;

   state_t           state, state_nxt;
   logic [2:0]       idx;
   logic [RAW_W-1:0] shifted;
   logic [2:0]       q;
   logic             beat;
   logic             res_hs;

   always_comb begin
      shifted = in_data >> QSHIFT;
      q       = (shifted > RAW_W'(7)) ? 3'd7 : shifted[2:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && idx == 3'd4) state_nxt = EVAL;
         end
         EVAL: state_nxt = HOLD;
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   assign beat   = in_valid & in_ready;
   assign res_hs = out_valid & out_ready;

   // clr_err is applied first so a same-cycle framing error overrides it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         feat_a    <= '0;
         feat_b    <= '0;
         feat_c    <= '0;
         feat_d    <= '0;
         feat_e    <= '0;
         out_class <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (clr_err) frame_err <= 1'b0;
         if (beat) begin
            case (idx)
               3'd0:    feat_a <= q;
               3'd1:    feat_b <= q;
               3'd2:    feat_c <= q;
               3'd3:    feat_d <= q;
               3'd4:    feat_e <= q;
               default: ;
            endcase
            if (idx == 3'd4) begin
               if (!in_last) frame_err <= 1'b1;
            end else if (in_last) begin
               frame_err <= 1'b1;
               idx       <= '0;
            end else begin
               idx <= idx + 3'd1;
            end
         end
         if (state == EVAL) out_class <= nrn_out;
         if (res_hs)        idx       <= '0;
      end
   end

`ifdef TNN_LOADER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_total <= '0;
         stat_pos   <= '0;
      end else if (stat_clr) begin
         stat_total <= '0;
         stat_pos   <= '0;
      end else if (res_hs) begin
         if (stat_total != '1)            stat_total <= stat_total + 1'b1;
         if (out_class && stat_pos != '1) stat_pos   <= stat_pos + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Directed bench for tnn_feature_loader: two instances (QSHIFT=5 and QSHIFT=3) share one input stream,
// each driving a stub neuron nrn = (a+b) > (c+d+e).
module tb_tnn_feature_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_last, out_ready, clr_err, stat_clr;
   logic [7:0] in_data;

   logic       in_ready, out_valid, out_class, frame_err, nrn;
   logic [2:0] fa, fb, fc, fd, fe;
   logic       in_ready3, out_valid3, out_class3, frame_err3, nrn3;
   logic [2:0] fa3, fb3, fc3, fd3, fe3;
   logic [1:0] st_total, st_pos, st_total3, st_pos3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign nrn  = ({2'b0, fa} + {2'b0, fb}) > ({2'b0, fc} + {2'b0, fd} + {2'b0, fe});
   assign nrn3 = ({2'b0, fa3} + {2'b0, fb3}) > ({2'b0, fc3} + {2'b0, fd3} + {2'b0, fe3});

   tnn_feature_loader #(.RAW_W(8), .QSHIFT(5), .STAT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .feat_a(fa), .feat_b(fb), .feat_c(fc), .feat_d(fd), .feat_e(fe),
      .nrn_out(nrn), .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .frame_err(frame_err), .clr_err(clr_err)
`ifdef TNN_LOADER_STATS_EN
      , .stat_clr(stat_clr), .stat_total(st_total), .stat_pos(st_pos)
`endif
   );

   tnn_feature_loader #(.RAW_W(8), .QSHIFT(3), .STAT_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
      .in_last(in_last), .feat_a(fa3), .feat_b(fb3), .feat_c(fc3), .feat_d(fd3), .feat_e(fe3),
      .nrn_out(nrn3), .out_valid(out_valid3), .out_ready(out_ready), .out_class(out_class3),
      .frame_err(frame_err3), .clr_err(clr_err)
`ifdef TNN_LOADER_STATS_EN
      , .stat_clr(stat_clr), .stat_total(st_total3), .stat_pos(st_pos3)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // returns #1 after the edge that accepts beat 5 (FSM in EVAL)
   task automatic send_frame(input logic [7:0] d0, d1, d2, d3, d4, input logic l);
      send_beat(d0, 1'b0);
      send_beat(d1, 1'b0);
      send_beat(d2, 1'b0);
      send_beat(d3, 1'b0);
      send_beat(d4, l);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic pulse_clr_err();
      @(negedge clk);
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      out_ready = 1'b0; clr_err = 1'b0; stat_clr = 1'b0;
      #12;
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_class", out_class, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_feats", {fa, fb, fc, fd, fe}, 0);
      @(negedge clk); rst_n = 1'b1;

      // basic frame, latency
      send_frame(8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 1'b1);
      chk("t1_eval_valid", out_valid, 0);
      chk("t1_eval_ready", in_ready, 0);
      chk("t1_feats",  {fa, fb, fc, fd, fe},      {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
      chk("t1_feats3", {fa3, fb3, fc3, fd3, fe3}, {3'd4, 3'd7, 3'd7, 3'd7, 3'd7});
      step();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_class", out_class, 0);
      chk("t1_frame_err", frame_err, 0);
      chk("t1_out_class3", out_class3, 0);
      handshake();
      chk("t1_hs_valid", out_valid, 0);
      chk("t1_hs_ready", in_ready, 1);

      // quantisation / saturation
      send_frame(8'hFF, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1);
      chk("t2_feats3", {fa3, fb3, fc3, fd3, fe3}, {3'd7, 3'd2, 3'd0, 3'd0, 3'd0});
      chk("t2_feats",  {fa, fb, fc, fd, fe},      {3'd7, 3'd0, 3'd0, 3'd0, 3'd0});
      step();
      chk("t2_class3", out_class3, 1);
      chk("t2_class",  out_class, 1);
      handshake();
      send_frame(8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00, 1'b1);
      chk("t2b_feats3", {fa3, fb3, fc3, fd3, fe3}, {3'd7, 3'd7, 3'd0, 3'd0, 3'd0});
      step();
      chk("t2b_class3", out_class3, 1);
      handshake();

      // short frame, recovery, clear, set-wins, missing in_last
      send_beat(8'h20, 1'b0);
      send_beat(8'h20, 1'b0);
      send_beat(8'h20, 1'b1);
      chk("t3_frame_err", frame_err, 1);
      chk("t3_feats", {fa, fb, fc, fd, fe}, {3'd1, 3'd1, 3'd1, 3'd0, 3'd0});
      step(); step();
      chk("t3_no_valid", out_valid, 0);
      chk("t3_in_ready", in_ready, 1);
      send_frame(8'h60, 8'h40, 8'h20, 8'h00, 8'h00, 1'b1);
      chk("t3_feats2", {fa, fb, fc, fd, fe}, {3'd3, 3'd2, 3'd1, 3'd0, 3'd0});
      step();
      chk("t3_valid2", out_valid, 1);
      chk("t3_class2", out_class, 1);
      chk("t3_sticky", frame_err, 1);
      handshake();
      pulse_clr_err();
      chk("t3_clr", frame_err, 0);
      @(negedge clk);
      clr_err = 1'b1; in_valid = 1'b1; in_data = 8'h20; in_last = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      chk("t3_set_wins", frame_err, 1);
      pulse_clr_err();
      chk("t3_clr2", frame_err, 0);
      send_frame(8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 1'b0);
      chk("t3_nolast_err", frame_err, 1);
      step();
      chk("t3_nolast_valid", out_valid, 1);
      handshake();
      pulse_clr_err();

      // backpressure
      send_frame(8'h60, 8'h40, 8'h20, 8'h00, 8'h00, 1'b1);
      step();
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t4_valid", out_valid, 1);
         chk("t4_class", out_class, 1);
         chk("t4_ready", in_ready, 0);
         chk("t4_feats", {fa, fb, fc, fd, fe}, {3'd3, 3'd2, 3'd1, 3'd0, 3'd0});
      end
      in_valid = 1'b0; in_last = 1'b0;
      handshake();
      chk("t4_hs_ready", in_ready, 1);
      chk("t4_hs_valid", out_valid, 0);
      chk("t4_frame_err", frame_err, 0);

      // async reset in EVAL and in HOLD
      send_frame(8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 1'b1);
      rst_n = 1'b0; #1;
      chk("t5e_ready", in_ready, 1);
      chk("t5e_valid", out_valid, 0);
      chk("t5e_feats", {fa, fb, fc, fd, fe}, 0);
      @(negedge clk); rst_n = 1'b1;
      send_frame(8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      chk("t5h_pre_valid", out_valid, 1);
      chk("t5h_pre_err", frame_err, 1);
      rst_n = 1'b0; #1;
      chk("t5h_valid", out_valid, 0);
      chk("t5h_class", out_class, 0);
      chk("t5h_err", frame_err, 0);
      chk("t5h_feats", {fa, fb, fc, fd, fe}, 0);
      @(negedge clk); rst_n = 1'b1;
      send_frame(8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 1'b1);
      chk("t5_feats", {fa, fb, fc, fd, fe}, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
      step();
      chk("t5_valid", out_valid, 1);
      chk("t5_class", out_class, 0);
      handshake();

`ifdef TNN_LOADER_STATS_EN
      @(negedge clk); stat_clr = 1'b1;
      @(posedge clk); #1; stat_clr = 1'b0;
      chk("t6_clr0_total", st_total, 0);
      chk("t6_clr0_pos", st_pos, 0);
      for (int f = 0; f < 4; f++) begin
         if (f < 3) send_frame(8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00, 1'b1);
         else       send_frame(8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 1'b1);
         step();
         handshake();
         if (f == 1) begin
            chk("t6_mid_total", st_total, 2);
            chk("t6_mid_pos", st_pos, 2);
         end
      end
      chk("t6_total", st_total, 3);
      chk("t6_pos", st_pos, 3);
      chk("t6_total3", st_total3, 3);
      @(negedge clk); stat_clr = 1'b1;
      @(posedge clk); #1; stat_clr = 1'b0;
      chk("t6_clr_total", st_total, 0);
      chk("t6_clr_pos", st_pos, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
